// File: rtl/ps2_key_decoder.sv
// Pops PS/2 set-2 scancodes from the keyboard FIFO and tracks the held key, shift state,
// make/break/extended prefixes and a keypress count, with an ASCII view of the held key.
module ps2_key_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       kbd_data,
   input  logic             kbd_ready,
   input  logic             kbd_overflow,
   output logic             kbd_nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic [7:0]       key_ascii,
   output logic             key_repeat,
   output logic             shift_held,
   output logic [CNT_W-1:0] press_cnt,
   output logic             overflow_flag
);

   typedef enum logic {IDLE, DECODE} state_t;

   localparam logic [7:0] CODE_BRK    = 8'hF0;
   localparam logic [7:0] CODE_EXT    = 8'hE0;
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic             break_pend_q, break_pend_d;
   logic             ext_pend_q, ext_pend_d;
   logic             key_valid_q, key_valid_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_ext_q, key_ext_d;
   logic             key_repeat_q, key_repeat_d;
   logic             shift_held_q, shift_held_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic             overflow_q, overflow_d;

   // Lowercase letters are folded to uppercase afterwards when shift is held.
   function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic shift);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      if (shift && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
      return a;
   endfunction

   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      nextdata_n_d = 1'b1;
      break_pend_d = break_pend_q;
      ext_pend_d   = ext_pend_q;
      key_valid_d  = key_valid_q;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      key_repeat_d = 1'b0;
      shift_held_d = shift_held_q;
      press_cnt_d  = press_cnt_q;
      overflow_d   = overflow_q | kbd_overflow;
      case (state_q)
         IDLE: begin
            if (kbd_ready) begin
               byte_d       = kbd_data;
               nextdata_n_d = 1'b0;
               state_d      = DECODE;
            end
         end
         DECODE: begin
            state_d = IDLE;
            if (byte_q == CODE_BRK) begin
               break_pend_d = 1'b1;
            end else if (byte_q == CODE_EXT) begin
               ext_pend_d = 1'b1;
            end else begin
               if (break_pend_q) begin
                  if (byte_q == CODE_LSHIFT || byte_q == CODE_RSHIFT) begin
                     shift_held_d = 1'b0;
                  end else if (byte_q == key_code_q && ext_pend_q == key_ext_q) begin
                     key_valid_d = 1'b0;
                  end
               end else if ((byte_q == CODE_LSHIFT || byte_q == CODE_RSHIFT) && !ext_pend_q) begin
                  shift_held_d = 1'b1;
               end else if (key_valid_q && byte_q == key_code_q && ext_pend_q == key_ext_q) begin
                  key_repeat_d = 1'b1;
               end else begin
                  key_code_d  = byte_q;
                  key_ext_d   = ext_pend_q;
                  key_valid_d = 1'b1;
                  press_cnt_d = press_cnt_q + CNT_W'(1);
               end
               break_pend_d = 1'b0;
               ext_pend_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         nextdata_n_q <= 1'b1;
         break_pend_q <= 1'b0;
         ext_pend_q   <= 1'b0;
         key_valid_q  <= 1'b0;
         key_code_q   <= 8'h00;
         key_ext_q    <= 1'b0;
         key_repeat_q <= 1'b0;
         shift_held_q <= 1'b0;
         press_cnt_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         nextdata_n_q <= nextdata_n_d;
         break_pend_q <= break_pend_d;
         ext_pend_q   <= ext_pend_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         key_repeat_q <= key_repeat_d;
         shift_held_q <= shift_held_d;
         press_cnt_q  <= press_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   // The latched byte is only consumed in DECODE, so it needs no reset.
   always_ff @(posedge clk) begin
      byte_q <= byte_d;
   end

   assign kbd_nextdata_n = nextdata_n_q;
   assign key_valid      = key_valid_q;
   assign key_code       = key_code_q;
   assign key_ext        = key_ext_q;
   assign key_repeat     = key_repeat_q;
   assign shift_held     = shift_held_q;
   assign press_cnt      = press_cnt_q;
   assign overflow_flag  = overflow_q;
   assign key_ascii      = (key_valid_q && !key_ext_q) ? ascii_lut(key_code_q, shift_held_q) : 8'h00;

endmodule
